// File: rtl/text_field_ctrl.sv
// Single-line text field renderer: line buffer, clear sweep, blink timer and a
// three-stage pixel pipeline that time-shares an external character ROM.
module text_field_ctrl #(
    parameter int X0           = 0,
    parameter int Y0           = 0,
    parameter int N_CHARS      = 16,
    parameter int SCALE_SHIFT  = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [9:0]                 px_x,
    input  logic [9:0]                 px_y,
    input  logic                       px_de,
    input  logic                       frame_tick,
    input  logic                       blink_en,
    input  logic                       wr_en,
    input  logic [$clog2(N_CHARS)-1:0] wr_idx,
    input  logic [7:0]                 wr_char,
    output logic                       wr_ready,
    input  logic                       clr_start,
    output logic                       busy,
    output logic [7:0]                 rom_ascii,
    output logic [3:0]                 rom_row,
    input  logic [7:0]                 rom_pixels,
    output logic                       pixel_on,
    output logic                       pixel_valid
);

    localparam int IDX_W = $clog2(N_CHARS);
    localparam int FIELD_W = (N_CHARS * 8) << SCALE_SHIFT;
    localparam int FIELD_H = 8 << SCALE_SHIFT;
    localparam int X1 = X0 + FIELD_W;
    localparam int Y1 = Y0 + FIELD_H;
    localparam logic [9:0] X0_10 = X0[9:0];
    localparam logic [9:0] Y0_10 = Y0[9:0];
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_CHARS - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic [7:0]         buf_reg [N_CHARS];
    logic [N_CHARS-1:0] slot_we;
    logic [7:0]         slot_wdata;
    logic               clr_we;
    logic               wr_fire;

    logic [7:0] bcnt_reg;
    logic       phase_reg;
    logic       visible;

    logic [31:0]      px_x_w;
    logic [31:0]      px_y_w;
    logic             hit;
    logic [9:0]       dx;
    logic [9:0]       dy;
    logic [IDX_W-1:0] char_idx;
    logic [2:0]       bit_col;
    logic [2:0]       glyph_row;

    logic [7:0] rom_ascii_reg;
    logic [3:0] rom_row_reg;
    logic       hit1_reg;
    logic [2:0] col1_reg;
    logic       de1_reg;
    logic       hit2_reg;
    logic [2:0] col2_reg;
    logic       de2_reg;
    logic       pixel_on_reg;
    logic       pixel_valid_reg;

    assign wr_ready = !busy_reg && !clr_start;
    assign busy     = busy_reg;
    assign wr_fire  = wr_en && wr_ready;
    assign clr_we   = (state_reg == S_CLEAR);

    // Sweep writes and host writes never overlap: wr_ready is low throughout the sweep.
    assign slot_wdata = clr_we ? SPACE : wr_char;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHARS; gi++) begin : g_slot_we
            assign slot_we[gi] = (clr_we  && (cnt_reg == IDX_W'(gi))) ||
                                 (wr_fire && (wr_idx  == IDX_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CHARS; i++) begin
                buf_reg[i] <= SPACE;
            end
        end else begin
            for (int i = 0; i < N_CHARS; i++) begin
                if (slot_we[i]) begin
                    buf_reg[i] <= slot_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (clr_start) begin
                        state_reg <= S_CLEAR;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_SLOT) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Blink timer is held cleared whenever blinking is disabled, even on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_reg  <= 8'd0;
            phase_reg <= 1'b0;
        end else if (!blink_en) begin
            bcnt_reg  <= 8'd0;
            phase_reg <= 1'b0;
        end else if (frame_tick) begin
            if (bcnt_reg == BLINK_LAST) begin
                bcnt_reg  <= 8'd0;
                phase_reg <= !phase_reg;
            end else begin
                bcnt_reg <= bcnt_reg + 8'd1;
            end
        end
    end

    assign visible = !blink_en || !phase_reg;

    // Bounds are compared at full width so a field near the screen edge cannot wrap.
    assign px_x_w = {22'd0, px_x};
    assign px_y_w = {22'd0, px_y};
    assign hit = px_de &&
                 (px_x_w >= 32'(X0)) && (px_x_w < 32'(X1)) &&
                 (px_y_w >= 32'(Y0)) && (px_y_w < 32'(Y1));

    assign dx        = hit ? (px_x - X0_10) : 10'd0;
    assign dy        = hit ? (px_y - Y0_10) : 10'd0;
    assign char_idx  = IDX_W'(dx >> (SCALE_SHIFT + 3));
    assign bit_col   = 3'(dx >> SCALE_SHIFT);
    assign glyph_row = 3'(dy >> SCALE_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_ascii_reg   <= SPACE;
            rom_row_reg     <= 4'd0;
            hit1_reg        <= 1'b0;
            col1_reg        <= 3'd0;
            de1_reg         <= 1'b0;
            hit2_reg        <= 1'b0;
            col2_reg        <= 3'd0;
            de2_reg         <= 1'b0;
            pixel_on_reg    <= 1'b0;
            pixel_valid_reg <= 1'b0;
        end else begin
            rom_ascii_reg   <= hit ? buf_reg[char_idx] : SPACE;
            rom_row_reg     <= hit ? {1'b0, glyph_row} : 4'd0;
            hit1_reg        <= hit && visible;
            col1_reg        <= bit_col;
            de1_reg         <= px_de;
            // ROM read happens during this stage; flags ride alongside.
            hit2_reg        <= hit1_reg;
            col2_reg        <= col1_reg;
            de2_reg         <= de1_reg;
            pixel_on_reg    <= hit2_reg && rom_pixels[3'd7 - col2_reg];
            pixel_valid_reg <= de2_reg;
        end
    end

    assign rom_ascii   = rom_ascii_reg;
    assign rom_row     = rom_row_reg;
    assign pixel_on    = pixel_on_reg;
    assign pixel_valid = pixel_valid_reg;

endmodule

// File: tb/tb_text_field_ctrl.sv
// Directed bench for text_field_ctrl with a registered character ROM model;
// field at X0=8, Y0=2, 16 chars, 2x scale (256x16 pixels), 2-frame blink.
module tb_text_field_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] px_x;
    logic [9:0] px_y;
    logic       px_de;
    logic       frame_tick;
    logic       blink_en;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [7:0] wr_char;
    logic       wr_ready;
    logic       clr_start;
    logic       busy;
    logic [7:0] rom_ascii;
    logic [3:0] rom_row;
    logic [7:0] rom_pixels = 8'h00;
    logic       pixel_on;
    logic       pixel_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_field_ctrl #(
        .X0(8), .Y0(2), .N_CHARS(16), .SCALE_SHIFT(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .px_x(px_x), .px_y(px_y), .px_de(px_de),
        .frame_tick(frame_tick), .blink_en(blink_en),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .wr_ready(wr_ready),
        .clr_start(clr_start), .busy(busy),
        .rom_ascii(rom_ascii), .rom_row(rom_row), .rom_pixels(rom_pixels),
        .pixel_on(pixel_on), .pixel_valid(pixel_valid)
    );

    // Character ROM: space is blank, 'B' uses a real glyph, anything else is a solid block.
    function automatic logic [7:0] glyph(input logic [7:0] a, input logic [2:0] r);
        if (a == 8'h20) return 8'h00;
        if (a == 8'h42) begin
            case (r)
                3'd0, 3'd6: return 8'b11111100;
                3'd3:       return 8'b01111100;
                3'd7:       return 8'b00000000;
                default:    return 8'b01100110;
            endcase
        end
        return 8'hFF;
    endfunction

    always @(posedge clk) rom_pixels <= glyph(rom_ascii, rom_row[2:0]);

    task automatic set_px(input int x, input int y, input logic de);
        px_x  = 10'(x);
        px_y  = 10'(y);
        px_de = de;
    endtask

    task automatic write_char(input int idx, input logic [7:0] ch);
        int guard;
        guard = 0;
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 4'(idx); wr_char = ch;
        while (!wr_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; failures++;
            $display("FAIL write_timeout slot=%0d wr_ready=%b required=1", idx, wr_ready);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        frame_tick = 0; blink_en = 0; wr_en = 0; wr_idx = 0; wr_char = 0; clr_start = 0;
        set_px(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (rom_ascii !== 8'h20) begin failures++; $display("FAIL reset_rom_ascii got=%h exp=20", rom_ascii); end
        checks++;
        if (rom_row !== 4'd0) begin failures++; $display("FAIL reset_rom_row got=%h exp=0", rom_row); end
        checks++;
        if (pixel_on !== 1'b0 || pixel_valid !== 1'b0) begin
            failures++; $display("FAIL reset_pixel got=%b%b exp=00", pixel_on, pixel_valid);
        end
        checks++;
        if (busy !== 1'b0 || wr_ready !== 1'b1) begin
            failures++; $display("FAIL reset_handshake busy=%b wr_ready=%b exp busy=0 wr_ready=1", busy, wr_ready);
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_blank_sweep;
        logic de_hist [20];
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (rom_ascii !== 8'h20) begin failures++; $display("FAIL blank_ascii i=%0d got=%h exp=20", i, rom_ascii); end
            end
            if (i >= 3) begin
                checks++;
                if (pixel_on !== 1'b0 || pixel_valid !== de_hist[i-3]) begin
                    failures++;
                    $display("FAIL blank_pixel i=%0d got on=%b valid=%b exp on=0 valid=%b", i, pixel_on, pixel_valid, de_hist[i-3]);
                end
            end
            if (i < 20) begin
                de_hist[i] = (i % 5) != 4;
                set_px(8 + i * 13, 2 + (i % 16), de_hist[i]);
            end else begin
                set_px(0, 0, 1'b0);
            end
        end
        $display("test_blank_sweep done");
    endtask

    // 'B' row 0 is 11111100; at 2x scale dx 0..11 are lit and dx 12..15 dark.
    task automatic test_glyph_b;
        write_char(0, 8'h42);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 16) begin
                checks++;
                if (rom_ascii !== 8'h42 || rom_row !== 4'd0) begin
                    failures++; $display("FAIL glyph_fetch i=%0d got=%h/%0d exp=42/0", i, rom_ascii, rom_row);
                end
            end
            if (i >= 3) begin
                checks++;
                if (pixel_on !== ((i - 3) < 12) || pixel_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL glyph_pixel dx=%0d got on=%b valid=%b exp on=%b valid=1", i - 3, pixel_on, pixel_valid, (i - 3) < 12);
                end
            end
            if (i < 16) set_px(8 + i, 2, 1'b1);
            else        set_px(0, 0, 1'b1);
        end
        set_px(0, 0, 1'b0);
        $display("test_glyph_b done");
    endtask

    task automatic test_edges;
        int         xs [6] = '{263, 264, 8, 7, 8, 8};
        int         ys [6] = '{2, 2, 1, 2, 17, 18};
        logic [7:0] ea [6] = '{8'h58, 8'h20, 8'h20, 8'h20, 8'h42, 8'h20};
        logic [3:0] er [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0};
        logic       ep [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        write_char(15, 8'h58);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 6) begin
                checks++;
                if (rom_ascii !== ea[i-1] || rom_row !== er[i-1]) begin
                    failures++;
                    $display("FAIL edge_fetch x=%0d y=%0d got=%h/%0d exp=%h/%0d", xs[i-1], ys[i-1], rom_ascii, rom_row, ea[i-1], er[i-1]);
                end
            end
            if (i >= 3) begin
                checks++;
                if (pixel_on !== ep[i-3]) begin
                    failures++; $display("FAIL edge_pixel x=%0d y=%0d got=%b exp=%b", xs[i-3], ys[i-3], pixel_on, ep[i-3]);
                end
            end
            if (i < 6) set_px(xs[i], ys[i], 1'b1);
            else       set_px(0, 0, 1'b0);
        end
        $display("test_edges done");
    endtask

    task automatic test_clear;
        logic [7:0] word [6] = '{8'h50, 8'h41, 8'h59, 8'h4F, 8'h55, 8'h54};
        int busy_cnt;
        for (int i = 0; i < 6; i++) write_char(i, word[i]);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (rom_ascii !== word[i-1]) begin
                    failures++; $display("FAIL payout_read slot=%0d got=%h exp=%h", i - 1, rom_ascii, word[i-1]);
                end
            end
            if (i < 6) set_px(8 + 16 * i, 2, 1'b1);
        end
        // Clear and write in the same cycle; slot 6 is watched to prove the write was dropped.
        set_px(104, 2, 1'b1);
        clr_start = 1'b1; wr_en = 1'b1; wr_idx = 4'd6; wr_char = 8'h5A;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL clr_vs_wr wr_ready=%b exp=0", wr_ready); end
        busy_cnt = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (k == 0) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy_rise got=%b exp=1", busy); end
            end
            if (busy === 1'b1) begin
                checks++;
                if (wr_ready !== 1'b0) begin failures++; $display("FAIL clear_wr_ready k=%0d got=%b exp=0", k, wr_ready); end
            end
            if (k >= 1) begin
                checks++;
                if (rom_ascii !== 8'h20) begin failures++; $display("FAIL dropped_write k=%0d got=%h exp=20", k, rom_ascii); end
            end
            if (k == 16) begin
                checks++;
                if (busy !== 1'b0 || wr_ready !== 1'b1) begin
                    failures++; $display("FAIL clear_end busy=%b wr_ready=%b exp busy=0 wr_ready=1", busy, wr_ready);
                end
            end
            if (k == 0) begin clr_start = 1'b0; wr_en = 1'b0; end
            if (k == 5) clr_start = 1'b1;
            if (k == 6) clr_start = 1'b0;
        end
        checks++;
        if (busy_cnt != 16) begin failures++; $display("FAIL clear_busy_len got=%0d exp=16", busy_cnt); end
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (rom_ascii !== 8'h20) begin failures++; $display("FAIL cleared_read slot=%0d got=%h exp=20", i - 1, rom_ascii); end
            end
            if (i < 16) set_px(8 + 16 * i, 2, 1'b1);
            else        set_px(0, 0, 1'b0);
        end
        $display("test_clear done");
    endtask

    task automatic test_blink;
        logic exp_vis [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        write_char(0, 8'h58);
        @(negedge clk);
        set_px(8, 2, 1'b1);
        blink_en = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (pixel_on !== 1'b1) begin failures++; $display("FAIL blink_start got=%b exp=1", pixel_on); end
        for (int t = 0; t < 6; t++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (4) @(negedge clk);
            checks++;
            if (pixel_on !== exp_vis[t]) begin
                failures++; $display("FAIL blink_tick%0d got=%b exp=%b", t + 1, pixel_on, exp_vis[t]);
            end
        end
        blink_en = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pixel_on !== 1'b1) begin failures++; $display("FAIL blink_disable got=%b exp=1", pixel_on); end
        // A tick coinciding with the disable edge must not toggle the phase.
        blink_en = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1; blink_en = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0; blink_en = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (pixel_on !== 1'b1) begin failures++; $display("FAIL blink_tick_on_disable got=%b exp=1", pixel_on); end
        blink_en = 1'b0;
        set_px(0, 0, 1'b0);
        $display("test_blink done");
    endtask

    task automatic test_reset_mid_clear;
        write_char(15, 8'h58);
        set_px(263, 2, 1'b1);
        repeat (4) @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || pixel_on !== 1'b1) begin
            failures++; $display("FAIL pre_abort busy=%b on=%b exp busy=1 on=1", busy, pixel_on);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || pixel_on !== 1'b0 || pixel_valid !== 1'b0) begin
            failures++; $display("FAIL async_abort busy=%b on=%b valid=%b exp 0 0 0", busy, pixel_on, pixel_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (rom_ascii !== 8'h20) begin failures++; $display("FAIL abort_read slot=%0d got=%h exp=20", i - 1, rom_ascii); end
            end
            if (i < 16) set_px(8 + 16 * i, 2, 1'b1);
            else        set_px(0, 0, 1'b0);
        end
        $display("test_reset_mid_clear done");
    endtask

    initial begin
        test_reset();
        test_blank_sweep();
        test_glyph_b();
        test_edges();
        test_clear();
        test_blink();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_field_ctrl.md
# text_field_ctrl

Sequencer that shares one `character_rom` instance with a single on-screen text field, for example the BET, PAYOUT or YOU WIN banner. It holds an N-character line buffer that the game logic writes through a ready/valid port. Each VGA pixel inside the field is converted into a ROM fetch (`rom_ascii`, `rom_row`), and the returned glyph row is realigned into a registered `pixel_on` for the colour mux. It also provides a sweep-clear command and optional frame-based blinking.

## Interface
Parameters:
- `X0`, 0: left edge of the field in pixels.
- `Y0`, 0: top edge of the field in pixels.
- `N_CHARS`, 16: buffer length. Must be a power of 2, at most 64.
- `SCALE_SHIFT`, 1: glyph magnification of `2**SCALE_SHIFT`, range 0–3.
- `BLINK_FRAMES`, 30: frames per blink half-period. Must be at least 1.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `px_x` input 10: current pixel column.
- `px_y` input 10: current pixel row.
- `px_de` input 1: display-enable for the current pixel.
- `frame_tick` input 1: one-cycle pulse per frame.
- `blink_en` input 1: when 1, the field blinks.
- `wr_en` input 1: write request.
- `wr_idx` input `$clog2(N_CHARS)`: character slot to write.
- `wr_char` input 8: ASCII code to write.
- `wr_ready` output 1: write accepted when `wr_en & wr_ready`. Combinational, equal to `!busy & !clr_start`.
- `clr_start` input 1: request to fill the buffer with spaces.
- `busy` output 1: clear sweep in progress.
- `rom_ascii` output 8: to the ROM `ascii` input. Registered.
- `rom_row` output 4: to the ROM `row` input. Registered, bit 3 always 0.
- `rom_pixels` input 8: from the ROM. One-cycle registered latency; bit 7 is the leftmost pixel.
- `pixel_on` output 1: text pixel lit. Registered.
- `pixel_valid` output 1: `px_de` delayed to align with `pixel_on`.

## Operation
Region:
- `W = N_CHARS*8 << SCALE_SHIFT`, `H = 8 << SCALE_SHIFT`.
- A pixel hits the field when `px_de`, `X0 <= px_x < X0+W` and `Y0 <= px_y < Y0+H`.
- Offsets are computed as `dx = px_x-X0` and `dy = px_y-Y0` in 10-bit arithmetic, and only on a hit.
- Character index is `dx >> (SCALE_SHIFT+3)`.
- Bit column is `(dx >> SCALE_SHIFT) & 7`.
- Glyph row is `(dy >> SCALE_SHIFT) & 7`.

Pipeline:
- Stage 1 registers:
  - `rom_ascii = buffer[char index]` on a hit, else 8'h20;
  - `rom_row` = glyph row on a hit, else 0;
  - `hit1 = hit & visible`;
  - `col1`;
  - `de1 = px_de`.
- Stage 2 registers `hit2`, `col2` and `de2` while the ROM performs its read.
- Stage 3 registers `pixel_on = hit2 & rom_pixels[7-col2]` and `pixel_valid = de2`.

Buffer:
- `N_CHARS` x 8-bit registers, all 8'h20 after reset.
- A write lands at the clock edge; a stage-1 read in the same cycle returns the old value.

Clear FSM:
- States are IDLE and CLEAR.
- IDLE → CLEAR on `clr_start`. The clear counter loads 0 and `busy` rises at the next edge.
- In CLEAR, write 8'h20 to `buffer[cnt]`, then increment `cnt`. After slot `N_CHARS-1` is written, go to IDLE.
- `busy` is high for exactly `N_CHARS` cycles.
- `clr_start` while `busy` is ignored.
- `wr_en` while `wr_ready=0` is dropped; the requester must hold it.
- `clr_start` and `wr_en` in the same IDLE cycle: clear wins, the write is not accepted.
- Rendering continues during a clear and shows a mix of old characters and spaces.

Blink:
- 8-bit `bcnt` and 1-bit `phase`, both held at 0 while `blink_en=0`.
- On `frame_tick`, if `bcnt == BLINK_FRAMES-1`, set `bcnt=0` and toggle `phase`; otherwise increment `bcnt`.
- `visible = !blink_en | !phase`.

## Timing
- Pixel inputs at cycle t produce `pixel_on`/`pixel_valid` at cycle t+3. The VGA sync outputs must be delayed by 3 to match.
- Throughput is one pixel per clock with no stalls.
- Reset values: `rom_ascii` 8'h20, `rom_row` 0, `pixel_on` 0, `pixel_valid` 0, `busy` 0, FSM IDLE, `bcnt` 0, `phase` 0, all pipeline flags 0.
- `wr_ready` is 1 out of reset.
- Asserting `rst` mid-clear aborts the sweep. The buffer is forced back to all spaces and `busy` drops immediately.
- Edge pixels:
  - `px_x = X0+W-1` is a hit.
  - `px_x = X0+W` is not.
  - `px_x < X0` must not produce an underflow hit.
- `frame_tick` in the same cycle as a `blink_en` 1→0 edge: the counter and phase clear, no toggle.

## Test plan
- After reset, sweep the field with the ROM model attached → `pixel_on` is 0 everywhere, `rom_ascii` = 8'h20, `pixel_valid` follows `px_de` 3 cycles late.
- Write `"B"` to slot 0 with `SCALE_SHIFT=1`, `X0=Y0=0`, then present x=0..15, y=0 → `rom_ascii` = 8'h42, `rom_row` = 0, and `pixel_on` at t+3 reproduces 11111100 with each bit doubled.
- Present x = X0+W-1 then X0+W, and y = Y0-1 → the first is a hit and its ROM fetch is issued, the second is not, and y = Y0-1 gives `pixel_on`=0.
- Fill "PAYOUT", pulse `clr_start` together with `wr_en` → the write is not accepted, `busy` is high for 16 cycles, `wr_ready`=0 throughout, and the buffer reads all 8'h20 afterwards. A `clr_start` mid-sweep does not extend it.
- `blink_en=1`, `BLINK_FRAMES=2`, drive 4 `frame_tick` pulses → lit field pixels go dark after tick 2 and return after tick 4. Dropping `blink_en` restores them immediately.
- Assert `rst` during cycle 5 of a clear → `busy`=0 and `pixel_on`=0 asynchronously, and the buffer reads all spaces after release.
